// File: rtl/cp0_pkg.sv
// Shared CP0 timer register map: register numbers, selects and TimerCtl field offsets.
package cp0_pkg;

  localparam logic [4:0] CP0_REG_COUNT    = 5'd9;
  localparam logic [4:0] CP0_REG_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_REG_TIMERCTL = 5'd22;
  localparam logic [4:0] CP0_REG_PERIOD   = 5'd22;

  localparam logic [2:0] CP0_SEL_COUNT       = 3'd0;
  localparam logic [2:0] CP0_SEL_TIMERCTL    = 3'd0;
  localparam int         CP0_SEL_PERIOD_BASE = 1;

  localparam int TCTL_EN_LSB   = 0;
  localparam int TCTL_PER_LSB  = 4;
  localparam int TCTL_PEND_LSB = 8;
  localparam int TCTL_W1C_LSB  = 16;

  function automatic logic reg_hit(input logic [4:0] addr, input logic [2:0] sel,
                                   input logic [4:0] reg_num, input logic [2:0] reg_sel);
    return (addr == reg_num) && (sel == reg_sel);
  endfunction

endpackage

// File: rtl/cp0_timer_chan.sv
// One compare channel: Compare, optional Period, sticky pending flag and match/reload.
// Periodic reload exists only when CP0_TIMER_AUTORELOAD_EN is defined.
module cp0_timer_chan #(
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmp_we_i,
  input  logic               per_we_i,
  input  logic [COUNT_W-1:0] wdata_i,
  input  logic               en_i,
  input  logic               periodic_i,
  input  logic               w1c_i,
  input  logic               tick_i,
  input  logic [COUNT_W-1:0] count_inc_i,
  output logic [COUNT_W-1:0] cmp_o,
  output logic [COUNT_W-1:0] per_o,
  output logic               pend_o
);

  logic [COUNT_W-1:0] cmp_q, cmp_d;
  logic               pend_q, pend_d;
  logic               match;
  logic               reload;

  // tick_i is already suppressed on cycles where software writes Count
  assign match = en_i && tick_i && (count_inc_i == cmp_q);

`ifdef CP0_TIMER_AUTORELOAD_EN
  logic [COUNT_W-1:0] per_q;

  assign reload = match && periodic_i;
  assign per_o  = per_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) per_q <= '0;
    else if (per_we_i) per_q <= wdata_i;
  end
`else
  logic unused_ok;

  assign unused_ok = &{1'b0, per_we_i, periodic_i};
  assign reload    = 1'b0;
  assign per_o     = '0;
`endif

  // Software Compare write beats both reload and pending set; set beats W1C
  always_comb begin
    cmp_d  = cmp_q;
    pend_d = pend_q;
    if (cmp_we_i) begin
      cmp_d  = wdata_i;
      pend_d = 1'b0;
    end else begin
      if (reload) cmp_d = cmp_q + per_o;
      if (match) pend_d = 1'b1;
      else if (w1c_i) pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      cmp_q  <= cmp_d;
      pend_q <= pend_d;
    end
  end

  assign cmp_o  = cmp_q;
  assign pend_o = pend_q;

endmodule

// File: rtl/cp0_timer_bank.sv
// CP0 Count with prescaler, NUM_CMP compare channels, TimerCtl and read mux.
// Optional periodic reload: define CP0_TIMER_AUTORELOAD_EN.
module cp0_timer_bank
  import cp0_pkg::*;
#(
  parameter int NUM_CMP = 2,
  parameter int COUNT_W = 32,
  parameter int CNT_DIV = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we,
  input  logic [4:0]         wr_addr,
  input  logic [2:0]         wr_sel,
  input  logic [31:0]        data_i,
  input  logic [4:0]         rd_addr,
  input  logic [2:0]         rd_sel,
  output logic [31:0]        data_o,
  input  logic               count_disable,
  output logic [NUM_CMP-1:0] timer_int,
  output logic               timer_int_any
);

  logic [COUNT_W-1:0] count_q, count_d, count_inc;
  logic               phase_q, phase_d;
  logic [NUM_CMP-1:0] en_q;
  logic [NUM_CMP-1:0] per_mode_q;
  logic               count_wr, tctl_wr, tick, tick_m;
  logic [NUM_CMP-1:0] cmp_we, per_we, w1c, pend;
  logic [COUNT_W-1:0] cmp_w [NUM_CMP];
  logic [COUNT_W-1:0] per_w [NUM_CMP];

  assign count_wr  = we && reg_hit(wr_addr, wr_sel, CP0_REG_COUNT, CP0_SEL_COUNT);
  assign tctl_wr   = we && reg_hit(wr_addr, wr_sel, CP0_REG_TIMERCTL, CP0_SEL_TIMERCTL);
  assign tick      = !count_disable && ((CNT_DIV == 1) || phase_q);
  assign tick_m    = tick && !count_wr;
  assign count_inc = count_q + 1'b1;
  assign w1c       = tctl_wr ? data_i[TCTL_W1C_LSB +: NUM_CMP] : '0;

  always_comb begin
    phase_d = phase_q;
    count_d = count_q;
    if (count_wr) begin
      phase_d = 1'b0;
      count_d = data_i[COUNT_W-1:0];
    end else begin
      if (!count_disable && (CNT_DIV == 2)) phase_d = ~phase_q;
      if (tick) count_d = count_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      phase_q    <= 1'b0;
      en_q       <= '0;
      per_mode_q <= '0;
    end else begin
      count_q <= count_d;
      phase_q <= phase_d;
      if (tctl_wr) begin
        en_q <= data_i[TCTL_EN_LSB +: NUM_CMP];
`ifdef CP0_TIMER_AUTORELOAD_EN
        per_mode_q <= data_i[TCTL_PER_LSB +: NUM_CMP];
`endif
      end
    end
  end

  for (genvar k = 0; k < NUM_CMP; k++) begin : g_chan
    assign cmp_we[k] = we && reg_hit(wr_addr, wr_sel, CP0_REG_COMPARE, 3'(k));
`ifdef CP0_TIMER_AUTORELOAD_EN
    assign per_we[k] = we && reg_hit(wr_addr, wr_sel, CP0_REG_PERIOD, 3'(k + CP0_SEL_PERIOD_BASE));
`else
    assign per_we[k] = 1'b0;
`endif
    cp0_timer_chan #(.COUNT_W(COUNT_W)) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmp_we_i   (cmp_we[k]),
      .per_we_i   (per_we[k]),
      .wdata_i    (data_i[COUNT_W-1:0]),
      .en_i       (en_q[k]),
      .periodic_i (per_mode_q[k]),
      .w1c_i      (w1c[k]),
      .tick_i     (tick_m),
      .count_inc_i(count_inc),
      .cmp_o      (cmp_w[k]),
      .per_o      (per_w[k]),
      .pend_o     (pend[k])
    );
  end

  // Register contents are all zero under reset, so the read mux needs no reset gate
  always_comb begin
    data_o = '0;
    if (reg_hit(rd_addr, rd_sel, CP0_REG_COUNT, CP0_SEL_COUNT)) begin
      data_o[COUNT_W-1:0] = count_q;
    end else if (rd_addr == CP0_REG_COMPARE) begin
      for (int k = 0; k < NUM_CMP; k++)
        if (rd_sel == 3'(k)) data_o[COUNT_W-1:0] = cmp_w[k];
    end else if (reg_hit(rd_addr, rd_sel, CP0_REG_TIMERCTL, CP0_SEL_TIMERCTL)) begin
      data_o[TCTL_EN_LSB +: NUM_CMP]   = en_q;
      data_o[TCTL_PER_LSB +: NUM_CMP]  = per_mode_q;
      data_o[TCTL_PEND_LSB +: NUM_CMP] = pend;
    end else if (rd_addr == CP0_REG_PERIOD) begin
      for (int k = 0; k < NUM_CMP; k++)
        if (rd_sel == 3'(k + CP0_SEL_PERIOD_BASE)) data_o[COUNT_W-1:0] = per_w[k];
    end
  end

  assign timer_int     = pend;
  assign timer_int_any = |pend;

endmodule

// File: tb/tb_cp0_timer_bank.sv
// Directed bench for cp0_timer_bank: CNT_DIV=2 main instance plus a CNT_DIV=1 instance on shared inputs.
module tb_cp0_timer_bank;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        we = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [2:0]  wr_sel = '0;
  logic [31:0] data_i = '0;
  logic [4:0]  rd_addr = '0;
  logic [2:0]  rd_sel = '0;
  logic        count_disable = 1'b0;
  logic [31:0] data_o2, data_o1;
  logic [1:0]  int2, int1;
  logic        any2, any1;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  cp0_timer_bank #(.NUM_CMP(2), .COUNT_W(32), .CNT_DIV(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .we(we), .wr_addr(wr_addr), .wr_sel(wr_sel),
    .data_i(data_i), .rd_addr(rd_addr), .rd_sel(rd_sel), .data_o(data_o2),
    .count_disable(count_disable), .timer_int(int2), .timer_int_any(any2));

  cp0_timer_bank #(.NUM_CMP(2), .COUNT_W(32), .CNT_DIV(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .we(we), .wr_addr(wr_addr), .wr_sel(wr_sel),
    .data_i(data_i), .rd_addr(rd_addr), .rd_sel(rd_sel), .data_o(data_o1),
    .count_disable(count_disable), .timer_int(int1), .timer_int_any(any1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [2:0] s, input logic [31:0] d);
    we = 1'b1; wr_addr = a; wr_sel = s; data_i = d;
    step();
    we = 1'b0; wr_addr = '0; wr_sel = '0; data_i = '0;
  endtask

  task automatic setrd(input logic [4:0] a, input logic [2:0] s);
    rd_addr = a; rd_sel = s;
    #1;
  endtask

  initial begin
    logic found;

    // asynchronous reset assertion with no clock edge
    #2 rst_n = 1'b0;
    #1;
    setrd(5'd9, 3'd0);
    chk("rst_count", data_o2, 32'h0);
    chk("rst_int", {30'h0, int2}, 32'h0);
    chk("rst_any", {31'h0, any2}, 32'h0);

    step(); step();
    rst_n = 1'b1;

    // first match: Compare0=5, enable0, CNT_DIV=2 -> Count=5 after edge 10
    wr(5'd11, 3'd0, 32'd5);
    wr(5'd22, 3'd0, 32'h1);
    repeat (7) step();
    setrd(5'd9, 3'd0);
    chk("pre_match_count", data_o2, 32'd4);
    chk("pre_match_int", {30'h0, int2}, 32'h0);
    step();
    chk("match_count", data_o2, 32'd5);
    chk("match_int", {30'h0, int2}, 32'h1);
    chk("match_any", {31'h0, any2}, 32'h1);

    repeat (3) step();
    chk("sticky_count", data_o2, 32'd6);
    chk("sticky_int", {30'h0, int2}, 32'h1);

    // freeze with phase=1 held; first edge after release must tick
    count_disable = 1'b1;
    repeat (7) step();
    chk("frozen_count", data_o2, 32'd6);
    chk("frozen_int", {30'h0, int2}, 32'h1);
    count_disable = 1'b0;
    step();
    chk("resume_count", data_o2, 32'd7);

    wr(5'd22, 3'd0, 32'h0001_0001);
    setrd(5'd22, 3'd0);
    chk("w1c_int", {30'h0, int2}, 32'h0);
    chk("w1c_tctl", data_o2, 32'h1);

    // Compare write coincident with a match
    wr(5'd9, 3'd0, 32'd100);
    wr(5'd11, 3'd0, 32'd102);
    step(); step();
    wr(5'd11, 3'd0, 32'd200);
    chk("cmpwr_int", {30'h0, int2}, 32'h0);
    setrd(5'd11, 3'd0);
    chk("cmpwr_cmp", data_o2, 32'd200);
    setrd(5'd9, 3'd0);
    chk("cmpwr_count", data_o2, 32'd102);

    // W1C coincident with a match: set wins
    wr(5'd9, 3'd0, 32'd300);
    wr(5'd11, 3'd0, 32'd301);
    wr(5'd22, 3'd0, 32'h0001_0001);
    chk("w1c_vs_match", {30'h0, int2}, 32'h1);
    wr(5'd22, 3'd0, 32'h0001_0001);
    chk("w1c_alone", {30'h0, int2}, 32'h0);

    // wrap to Compare1=0
    wr(5'd11, 3'd1, 32'd0);
    wr(5'd22, 3'd0, 32'h3);
    wr(5'd9, 3'd0, 32'hFFFF_FFFF);
    setrd(5'd9, 3'd0);
    chk("wrap_pre_d1", {31'h0, int1[1]}, 32'h0);
    chk("wrap_pre_cnt_d1", data_o1, 32'hFFFF_FFFF);
    step();
    chk("wrap_d1_int1", {31'h0, int1[1]}, 32'h1);
    chk("wrap_d1_count", data_o1, 32'h0);
    chk("wrap_d2_hold", data_o2, 32'hFFFF_FFFF);
    chk("wrap_d2_int1_pre", {31'h0, int2[1]}, 32'h0);
    step();
    chk("wrap_d2_int1", {31'h0, int2[1]}, 32'h1);
    chk("wrap_d2_count", data_o2, 32'h0);

    // write strobe low and unmapped addresses
    wr_addr = 5'd9; wr_sel = 3'd0; data_i = 32'h1234;
    step();
    wr_addr = '0; data_i = '0;
    chk("we_low", data_o2, 32'h0);
    wr(5'd9, 3'd1, 32'h55);
    setrd(5'd9, 3'd1);
    chk("unmapped", data_o2, 32'h0);
    wr(5'd22, 3'd1, 32'h77);
    setrd(5'd22, 3'd1);
`ifdef CP0_TIMER_AUTORELOAD_EN
    chk("period_rd", data_o2, 32'h77);
`else
    chk("period_rd", data_o2, 32'h0);
`endif
    wr(5'd22, 3'd0, 32'h0003_00F3);
    setrd(5'd22, 3'd0);
`ifdef CP0_TIMER_AUTORELOAD_EN
    chk("tctl_fields", data_o2 & 32'h000F_00FF, 32'h33);
`else
    chk("tctl_fields", data_o2 & 32'h000F_00FF, 32'h03);
`endif

    // mid-operation reset, away from the clock edge
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_tctl", data_o2, 32'h0);
    chk("mid_rst_int", {30'h0, int2}, 32'h0);
    chk("mid_rst_any", {31'h0, any2}, 32'h0);
    chk("mid_rst_int_d1", {30'h0, int1}, 32'h0);
    setrd(5'd9, 3'd0);
    chk("mid_rst_count", data_o2, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    chk("rel_e1_d2", data_o2, 32'd0);
    chk("rel_e1_d1", data_o1, 32'd1);
    step();
    chk("rel_e2_d2", data_o2, 32'd1);

`ifdef CP0_TIMER_AUTORELOAD_EN
    count_disable = 1'b1;
    wr(5'd11, 3'd0, 32'd10);
    wr(5'd22, 3'd1, 32'd10);
    wr(5'd22, 3'd0, 32'h11);
    wr(5'd9, 3'd0, 32'd0);
    count_disable = 1'b0;
    for (int m = 1; m <= 3; m++) begin
      found = 1'b0;
      for (int n = 0; n < 40 && !found; n++) begin
        step();
        if (int2[0]) found = 1'b1;
      end
      chk("reload_seen", {31'h0, found}, 32'h1);
      setrd(5'd9, 3'd0);
      chk("reload_count", data_o2, 32'(10 * m));
      setrd(5'd11, 3'd0);
      chk("reload_cmp", data_o2, 32'(10 * (m + 1)));
      wr(5'd22, 3'd0, 32'h0001_0011);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
